data_memory_lsu: RTL and testbench

//  Parametrised data memory with RV32I load/store sizing: LB/LH/LW/LBU/LHU and SB/SH/SW.

---
 rtl/data_memory_lsu.sv | 190 +++++++++++++++++++
 tb/tb_data_memory_lsu.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_lsu.sv
// data_memory_lsu
//   Data memory with RV32I load/store sizing (LB/LH/LW/LBU/LHU, SB/SH/SW).
//   It accepts one request at a time, returns loads after READ_LATENCY cycles
//   and flags illegal funct3, misaligned and out-of-range accesses.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_write             1 = store, 0 = load
//   req_funct3            RV32I funct3 of the access
//   req_address           byte address
//   req_data              store data (low bits used for SB/SH)
//   resp_valid/resp_ready response handshake
//   resp_data             extended load result; 0 for stores and errors
//   resp_error            the request was rejected
//   initial_values        memory image loaded while reset is high
//   memory_check          combinational view of the memory array
//   state_debug           current FSM state (IDLE=0, WAIT=1, RESP=2)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The request side is only sampled on that edge. Once resp_valid rises,
// resp_data and resp_error stay stable until the edge where resp_ready is high.
module data_memory_lsu #(
    parameter int DEPTH_WORDS  = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [2:0]                   req_funct3,
    input  logic [31:0]                  req_address,
    input  logic [31:0]                  req_data,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [31:0]                  resp_data,
    output logic                         resp_error,
    input  logic [DEPTH_WORDS-1:0][31:0] initial_values,
    output logic [DEPTH_WORDS-1:0][31:0] memory_check,
    output logic [1:0]                   state_debug
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // WAIT covers READ_LATENCY-1 cycles; the counter exits WAIT when it hits 0.
    localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 2);

    logic [1:0]                   state;
    logic [2:0]                   wait_cnt;
    logic [31:0]                  pipe_data;
    logic [DEPTH_WORDS-1:0][31:0] mem;

    logic              accept;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_val;
    logic [31:0]       wr_data;
    logic [3:0]        wr_be;
    logic              bad_funct3;
    logic              misaligned;
    logic              out_of_range;
    logic              req_err;

    assign req_ready    = (state == IDLE) && !reset;
    assign accept       = req_valid && req_ready;
    assign idx          = req_address[IDX_W+1:2];
    assign rd_word      = mem[idx];
    assign rd_byte      = rd_word[{req_address[1:0], 3'b000} +: 8];
    assign rd_half      = req_address[1] ? rd_word[31:16] : rd_word[15:0];
    assign memory_check = mem;
    assign state_debug  = state;

    // Request classification
    always_comb begin
        bad_funct3   = 1'b0;
        misaligned   = 1'b0;
        if (req_write)
            bad_funct3 = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
        else
            bad_funct3 = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        case (req_funct3[1:0])
            2'b01:   misaligned = req_address[0];
            2'b10:   misaligned = |req_address[1:0];
            default: misaligned = 1'b0;
        endcase
        // Compare the full word address so high address bits cannot alias.
        out_of_range = req_address[31:2] >= 30'(DEPTH_WORDS);
        req_err      = bad_funct3 || misaligned || out_of_range;
    end

    // Load extension and store lane steering
    always_comb begin
        load_val = 32'h0;
        case (req_funct3)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_val = rd_word;
            3'b100:  load_val = {24'h0, rd_byte};
            3'b101:  load_val = {16'h0, rd_half};
            default: load_val = 32'h0;
        endcase

        wr_data = req_data;
        wr_be   = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                wr_data = {4{req_data[7:0]}};
                wr_be   = 4'b0001 << req_address[1:0];
            end
            2'b01: begin
                wr_data = {2{req_data[15:0]}};
                wr_be   = req_address[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_data = req_data;
                wr_be   = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem        <= initial_values;
            state      <= IDLE;
            wait_cnt   <= 3'd0;
            pipe_data  <= 32'h0;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_data  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_data  <= 32'h0;
                        end else if (req_write) begin
                            for (int b = 0; b < 4; b++)
                                if (wr_be[b])
                                    mem[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b0;
                            resp_data  <= 32'h0;
                        end else if (READ_LATENCY == 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b0;
                            resp_data  <= load_val;
                        end else begin
                            // Result is captured now; WAIT only delays it.
                            state     <= WAIT;
                            wait_cnt  <= CNT_INIT;
                            pipe_data <= load_val;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_data  <= pipe_data;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_error <= 1'b0;
                        resp_data  <= 32'h0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_lsu.sv
module tb_data_memory_lsu;

    localparam int DEPTH = 32;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Index 0: READ_LATENCY=1 instance, index 1: READ_LATENCY=3 instance.
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0]        req_valid  = '0;
    logic [1:0]        req_write  = '0;
    logic [1:0]        resp_ready = '0;
    logic [1:0][2:0]   req_funct3 = '0;
    logic [1:0][31:0]  req_address = '0;
    logic [1:0][31:0]  req_data   = '0;
    wire  [1:0]        req_ready;
    wire  [1:0]        resp_valid;
    wire  [1:0]        resp_error;
    wire  [1:0][31:0]  resp_data;
    wire  [1:0][DEPTH-1:0][31:0] memory_check;
    wire  [1:0][1:0]   state_debug;
    logic [DEPTH-1:0][31:0] init_values;

    data_memory_lsu #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_funct3(req_funct3[0]), .req_address(req_address[0]), .req_data(req_data[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_data(resp_data[0]),
        .resp_error(resp_error[0]), .initial_values(init_values),
        .memory_check(memory_check[0]), .state_debug(state_debug[0])
    );

    data_memory_lsu #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(3)) dut_l3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_funct3(req_funct3[1]), .req_address(req_address[1]), .req_data(req_data[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_data(resp_data[1]),
        .resp_error(resp_error[1]), .initial_values(init_values),
        .memory_check(memory_check[1]), .state_debug(state_debug[1])
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    // Scoreboard
    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_mem_init(input string name, input int u);
        int bad;
        bad = -1;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (memory_check[u][i] !== init_values[i]) bad = i;
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: word %0d got %h, want %h", name, bad,
                     memory_check[u][bad], init_values[bad]);
        end
    endtask

    // Drivers
    task automatic issue(input int u, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data);
        int n;
        n = 0;
        @(negedge clk);
        req_valid[u]   = 1'b1;
        req_write[u]   = wr;
        req_funct3[u]  = f3;
        req_address[u] = addr;
        req_data[u]    = data;
        while (!req_ready[u] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[u]) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_ready_timeout u%0d: got 0, want 1 within 50 cycles", u);
            req_valid[u] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid[u]   = 1'b0;
        req_address[u] = $urandom;
        req_data[u]    = $urandom;
        req_funct3[u]  = 3'($urandom_range(0, 7));
    endtask

    // lat = number of rising edges from the accepting edge until resp_valid is seen
    task automatic collect(input int u, output logic [31:0] data, output logic err, output int lat);
        lat = 1;
        @(negedge clk);
        while (!resp_valid[u] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        data = resp_data[u];
        err  = resp_error[u];
    endtask

    task automatic release_resp(input int u);
        resp_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[u] = 1'b0;
    endtask

    // Vector table
    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_err;
        int          chk_idx;
        logic [31:0] chk_val;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] exp_data,
                           input logic exp_err, input int chk_idx, input logic [31:0] chk_val);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = addr; v.data = data;
        v.exp_data = exp_data; v.exp_err = exp_err;
        v.chk_idx = chk_idx; v.chk_val = chk_val;
        vq.push_back(v);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        logic        seen;

        for (int i = 0; i < DEPTH; i++) init_values[i] = 32'h1000_0000 | 32'(i);
        init_values[0] = 32'hDEAD_BEEF;
        init_values[1] = 32'h8899_AABB;
        init_values[2] = 32'h0000_0000;
        init_values[3] = 32'h0000_0000;

        //        wr    f3      addr          data          exp_data      err  chk  chk_val
        add_vec(1'b0, 3'b000, 32'd4,        32'h0,        32'hFFFF_FFBB, 1'b0, -1, 32'h0);
        add_vec(1'b0, 3'b100, 32'd7,        32'h0,        32'h0000_0088, 1'b0, -1, 32'h0);
        add_vec(1'b0, 3'b001, 32'd6,        32'h0,        32'hFFFF_8899, 1'b0, -1, 32'h0);
        add_vec(1'b0, 3'b101, 32'd6,        32'h0,        32'h0000_8899, 1'b0, -1, 32'h0);
        add_vec(1'b0, 3'b000, 32'd5,        32'h0,        32'hFFFF_FFAA, 1'b0, -1, 32'h0);
        add_vec(1'b0, 3'b010, 32'd4,        32'h0,        32'h8899_AABB, 1'b0, -1, 32'h0);
        add_vec(1'b1, 3'b000, 32'd9,        32'h0000_0055, 32'h0,        1'b0,  2, 32'h0000_5500);
        add_vec(1'b1, 3'b001, 32'd10,       32'h0000_1234, 32'h0,        1'b0,  2, 32'h1234_5500);
        add_vec(1'b0, 3'b010, 32'd8,        32'h0,        32'h1234_5500, 1'b0, -1, 32'h0);
        add_vec(1'b0, 3'b010, 32'd2,        32'h0,        32'h0,         1'b1,  2, 32'h1234_5500);
        add_vec(1'b1, 3'b010, 32'd128,      32'hFFFF_FFFF, 32'h0,        1'b1,  0, 32'hDEAD_BEEF);
        add_vec(1'b0, 3'b011, 32'd0,        32'h0,        32'h0,         1'b1, -1, 32'h0);
        add_vec(1'b1, 3'b100, 32'd8,        32'hFFFF_FFFF, 32'h0,        1'b1,  2, 32'h1234_5500);
        add_vec(1'b1, 3'b001, 32'd13,       32'hFFFF_FFFF, 32'h0,        1'b1,  3, 32'h0000_0000);
        add_vec(1'b1, 3'b010, 32'd12,       32'hCAFE_F00D, 32'h0,        1'b0,  3, 32'hCAFE_F00D);
        add_vec(1'b0, 3'b010, 32'd12,       32'h0,        32'hCAFE_F00D, 1'b0, -1, 32'h0);
        add_vec(1'b0, 3'b001, 32'd3,        32'h0,        32'h0,         1'b1, -1, 32'h0);
        add_vec(1'b0, 3'b010, 32'h8000_0004, 32'h0,       32'h0,         1'b1, -1, 32'h0);
        add_vec(1'b1, 3'b000, 32'd15,       32'h0000_00AB, 32'h0,        1'b0,  3, 32'hABFE_F00D);
        add_vec(1'b0, 3'b000, 32'd15,       32'h0,        32'hFFFF_FFAB, 1'b0, -1, 32'h0);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_req_ready_low", 32'(req_ready[0]), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready[0]), 32'd1);
        check("reset_resp_valid", 32'(resp_valid[0]), 32'd0);
        check("reset_resp_error", 32'(resp_error[0]), 32'd0);
        check("reset_resp_data", resp_data[0], 32'h0);
        check("reset_state", 32'(state_debug[0]), 32'(S_IDLE));
        check_mem_init("reset_mem", 0);

        // Table-driven transactions on the latency-1 instance
        for (int i = 0; i < vq.size(); i++) begin
            issue(0, vq[i].wr, vq[i].f3, vq[i].addr, vq[i].data);
            exp_q.push_back(vq[i].exp_data);
            collect(0, d, e, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd1);
            check($sformatf("v%0d_data", i), d, exp_q.pop_front());
            check($sformatf("v%0d_error", i), 32'(e), 32'(vq[i].exp_err));
            release_resp(0);
            if (vq[i].chk_idx >= 0)
                check($sformatf("v%0d_mem%0d", i, vq[i].chk_idx),
                      memory_check[0][vq[i].chk_idx], vq[i].chk_val);
        end

        // Latency 3 with back-pressure
        issue(1, 1'b0, 3'b010, 32'd0, 32'h0);
        collect(1, d, e, lat);
        check("l3_latency", 32'(lat), 32'd3);
        check("l3_data", d, 32'hDEAD_BEEF);
        check("l3_error", 32'(e), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("l3_hold%0d_valid", k), 32'(resp_valid[1]), 32'd1);
            check($sformatf("l3_hold%0d_data", k), resp_data[1], 32'hDEAD_BEEF);
            check($sformatf("l3_hold%0d_req_ready", k), 32'(req_ready[1]), 32'd0);
            check($sformatf("l3_hold%0d_state", k), 32'(state_debug[1]), 32'(S_RESP));
        end
        release_resp(1);
        @(negedge clk);
        check("l3_after_valid", 32'(resp_valid[1]), 32'd0);
        check("l3_after_state", 32'(state_debug[1]), 32'(S_IDLE));
        check("l3_after_req_ready", 32'(req_ready[1]), 32'd1);

        // Reset during WAIT of a load abandons it and restores memory
        issue(1, 1'b1, 3'b010, 32'd20, 32'h5A5A_5A5A);
        collect(1, d, e, lat);
        check("rst_store_error", 32'(e), 32'd0);
        release_resp(1);
        check("rst_store_mem5", memory_check[1][5], 32'h5A5A_5A5A);
        issue(1, 1'b0, 3'b010, 32'd20, 32'h0);
        @(negedge clk);
        check("rst_in_wait_state", 32'(state_debug[1]), 32'(S_WAIT));
        check("rst_in_wait_valid", 32'(resp_valid[1]), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_req_ready_low", 32'(req_ready[1]), 32'd0);
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen = seen | resp_valid[1];
        end
        check("rst_no_resp", 32'(seen), 32'd0);
        check_mem_init("rst_mem_restored", 1);
        check("rst_req_ready", 32'(req_ready[1]), 32'd1);
        check("rst_state", 32'(state_debug[1]), 32'(S_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
